// File: rtl/wbuf_gen_if.sv
// Bus bundle for the write-back buffer: output-stage capture side, store grant and
// memory write port. master drives the buffer inputs, slave is the buffer itself.
interface wbuf_gen_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 3
);
  logic          CLR_DP;
  logic          ACC_CTRL;
  logic [CW-1:0] ROW_TOTAL;
  logic          WRITE_IN;
  logic [AW-1:0] ODST_IN;
  logic [DW-1:0] DIN;
  logic          STORE_GNT;
  logic          MEM_RDY;
  logic          LOAD_DONE;
  logic          STORE_DONE;
  logic          INIT_DONE;
  logic          EN_WB;
  logic [AW-1:0] ODST_WB;
  logic [DW-1:0] WDATA_WB;
  logic          BUSY;
  logic          ERR_OVF;

  modport master (
    output CLR_DP, ACC_CTRL, ROW_TOTAL, WRITE_IN, ODST_IN, DIN, STORE_GNT, MEM_RDY,
    input  LOAD_DONE, STORE_DONE, INIT_DONE, EN_WB, ODST_WB, WDATA_WB, BUSY, ERR_OVF
  );

  modport slave (
    input  CLR_DP, ACC_CTRL, ROW_TOTAL, WRITE_IN, ODST_IN, DIN, STORE_GNT, MEM_RDY,
    output LOAD_DONE, STORE_DONE, INIT_DONE, EN_WB, ODST_WB, WDATA_WB, BUSY, ERR_OVF
  );
endinterface

// File: rtl/wbuf_gen.sv
// Write-back buffer between the MAC-array output stage and output memory.
// Zero-sweeps memory after reset, collects a tile of rows, waits for a store grant,
// then drains the rows under ready/valid backpressure.
// Optional macro WBUF_MERGE_EN: rows hitting an already-buffered address accumulate
// into that entry instead of taking a new one.
module wbuf_gen #(
  parameter int unsigned DW         = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 4,
  parameter int unsigned INIT_WORDS = 16,
  parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
  input logic       CLK,
  input logic       RST,
  wbuf_gen_if.slave bus
);
  localparam int unsigned   IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LastInit = AW'(INIT_WORDS - 1);
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);

  typedef enum logic [1:0] {StInit, StIdle, StWaitGnt, StStore} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic          active_q, active_d;
  logic          err_q, err_d;
  logic          init_done_q, init_done_d;
  logic          load_done_q, load_done_d;
  logic          store_done_q, store_done_d;
  logic          en_q, en_d;
  logic [AW-1:0] odst_q, odst_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic [CW-1:0] rt_eff;
  logic          accept;
  logic          cap;
  logic          ovf;
  logic          store_last;
  logic [IW-1:0] cnt_idx, rptr_nxt_idx;

  // Effective rows per tile: 0 means 1, anything above DEPTH saturates.
  always_comb begin
    rt_eff = bus.ROW_TOTAL;
    if (bus.ROW_TOTAL == '0) begin
      rt_eff = CW'(1);
    end else if (bus.ROW_TOTAL > DepthC) begin
      rt_eff = DepthC;
    end
  end

  assign accept       = en_q & bus.MEM_RDY;
  assign cap          = active_q & bus.WRITE_IN & (state_q == StIdle) & (cnt_q < rt_eff);
  // Rows arriving during the sweep are ignored rather than flagged.
  assign ovf          = active_q & bus.WRITE_IN & ~cap & (state_q != StInit);
  assign cnt_idx      = IW'(cnt_q);
  assign rptr_nxt_idx = IW'(rptr_q + CW'(1));

`ifdef WBUF_MERGE_EN
  logic          hit;
  logic [IW-1:0] hit_idx;

  // Lowest valid entry whose address matches the incoming row; descending scan so
  // the lowest index is assigned last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if ((CW'(k) < cnt_q) && (addr_q[k] == bus.ODST_IN)) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end
`endif

  // Next-state: sweep, collection, drain and datapath clear.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    rptr_d       = rptr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    active_d     = active_q;
    err_d        = err_q;
    init_done_d  = init_done_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    en_d         = en_q;
    odst_d       = odst_q;
    wdata_d      = wdata_q;
    store_last   = 1'b0;

    unique case (state_q)
      StInit: begin
        if (!en_q) begin
          // First cycle out of reset: start the sweep.
          en_d    = 1'b1;
          odst_d  = ptr_q;
          wdata_d = '0;
        end else if (accept) begin
          if (ptr_q == LastInit) begin
            en_d        = 1'b0;
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            ptr_d  = ptr_q + AW'(1);
            odst_d = ptr_q + AW'(1);
          end
        end
      end
      StIdle: begin
        if (cnt_q >= rt_eff) begin
          load_done_d = 1'b1;
          state_d     = StWaitGnt;
        end
      end
      StWaitGnt: begin
        if (bus.STORE_GNT) begin
          state_d = StStore;
          rptr_d  = '0;
          en_d    = 1'b1;
          odst_d  = addr_q[0];
          wdata_d = data_q[0];
        end
      end
      StStore: begin
        if (accept) begin
          if (rptr_q == cnt_q - CW'(1)) begin
            store_last   = 1'b1;
            en_d         = 1'b0;
            store_done_d = 1'b1;
            state_d      = StIdle;
            cnt_d        = '0;
            rptr_d       = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
              addr_d[i] = '0;
              data_d[i] = '0;
            end
          end else begin
            rptr_d  = rptr_q + CW'(1);
            odst_d  = addr_q[rptr_nxt_idx];
            wdata_d = data_q[rptr_nxt_idx];
          end
        end
      end
      default: state_d = StInit;
    endcase

    if (cap) begin
`ifdef WBUF_MERGE_EN
      if (hit) begin
        data_d[hit_idx] = data_q[hit_idx] + bus.DIN;
      end else begin
        addr_d[cnt_idx] = bus.ODST_IN;
        data_d[cnt_idx] = bus.DIN;
        cnt_d           = cnt_q + CW'(1);
      end
`else
      addr_d[cnt_idx] = bus.ODST_IN;
      data_d[cnt_idx] = bus.DIN;
      cnt_d           = cnt_q + CW'(1);
`endif
    end

    if (ovf) begin
      err_d = 1'b1;
    end

    // A new ACC_CTRL outranks the self-clear at end of store so it is never lost.
    if (store_last) begin
      active_d = 1'b0;
    end
    if (bus.ACC_CTRL) begin
      active_d = 1'b1;
    end

    if (bus.CLR_DP) begin
      active_d = 1'b0;
      err_d    = 1'b0;
      cnt_d    = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_d[i] = '0;
        data_d[i] = '0;
      end
      // The sweep is not interrupted; outside it everything returns to idle.
      if (state_q != StInit) begin
        state_d      = StIdle;
        rptr_d       = '0;
        en_d         = 1'b0;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      cnt_q        <= '0;
      rptr_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      active_q     <= 1'b0;
      err_q        <= 1'b0;
      init_done_q  <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      en_q         <= 1'b0;
      odst_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rptr_q       <= rptr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      active_q     <= active_d;
      err_q        <= err_d;
      init_done_q  <= init_done_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      en_q         <= en_d;
      odst_q       <= odst_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.LOAD_DONE  = load_done_q;
  assign bus.STORE_DONE = store_done_q;
  assign bus.INIT_DONE  = init_done_q;
  assign bus.EN_WB      = en_q;
  assign bus.ODST_WB    = odst_q;
  assign bus.WDATA_WB   = wdata_q;
  assign bus.BUSY       = (state_q == StWaitGnt) || (state_q == StStore);
  assign bus.ERR_OVF    = err_q;
endmodule

// File: tb/tb_wbuf_gen.sv
// Directed bench for wbuf_gen: reset sweep, stalled sweep, tile store, overflow,
// mid-store clear and same-address rows (merge or not, following WBUF_MERGE_EN).
module tb_wbuf_gen;
  localparam int unsigned DW = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned INIT_WORDS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int   n_load = 0;
  int   n_store = 0;
  int   last_init_cyc = -10;
  int   init_rise_cyc = -1;
  logic init_prev = 1'b0;

  wbuf_gen_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  wbuf_gen #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .INIT_WORDS(INIT_WORDS), .CW(CW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted memory write and output pulses, mid-cycle.
  always @(negedge clk) begin
    if (bus.EN_WB === 1'b1 && bus.MEM_RDY === 1'b1) begin
      wq_addr.push_back(bus.ODST_WB);
      wq_data.push_back(bus.WDATA_WB);
      if (bus.ODST_WB == AW'(INIT_WORDS - 1) && bus.INIT_DONE !== 1'b1) last_init_cyc = cyc;
    end
    if (bus.LOAD_DONE === 1'b1) n_load++;
    if (bus.STORE_DONE === 1'b1) n_store++;
    if (bus.INIT_DONE === 1'b1 && init_prev !== 1'b1) init_rise_cyc = cyc;
    init_prev = bus.INIT_DONE;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CLR_DP = 1'b0; bus.ACC_CTRL = 1'b0; bus.ROW_TOTAL = '0; bus.WRITE_IN = 1'b0;
    bus.ODST_IN = '0; bus.DIN = '0; bus.STORE_GNT = 1'b0; bus.MEM_RDY = 1'b1;
  endtask

  task automatic clear_log();
    wq_addr.delete(); wq_data.delete(); n_load = 0; n_store = 0;
  endtask

  task automatic row(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.WRITE_IN = 1'b1; bus.ODST_IN = a; bus.DIN = d;
    step();
    bus.WRITE_IN = 1'b0;
  endtask

  task automatic acc_pulse();
    bus.ACC_CTRL = 1'b1;
    step();
    bus.ACC_CTRL = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.CLR_DP = 1'b1;
    step();
    bus.CLR_DP = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({bus.EN_WB, bus.INIT_DONE, bus.BUSY, bus.ERR_OVF, bus.LOAD_DONE, bus.STORE_DONE,
         bus.ODST_WB, bus.WDATA_WB} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b id=%b busy=%b ovf=%b ld=%b sd=%b a=%h d=%h exp all 0",
               bus.EN_WB, bus.INIT_DONE, bus.BUSY, bus.ERR_OVF, bus.LOAD_DONE, bus.STORE_DONE,
               bus.ODST_WB, bus.WDATA_WB);
    end
    clear_log();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.INIT_DONE === 1'b1) break;
      step();
    end
    checks++;
    if (bus.INIT_DONE !== 1'b1) begin
      failures++; $display("FAIL init_done_timeout got=%b exp=1", bus.INIT_DONE);
    end
    step();
    checks++;
    if (wq_addr.size() != 16) begin
      failures++; $display("FAIL init_write_count got=%0d exp=16", wq_addr.size());
    end
    for (int i = 0; i < 16 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== '0) begin
        failures++;
        $display("FAIL init_write[%0d] got=%h:%h exp=%h:0", i, wq_addr[i], wq_data[i], i);
      end
    end
    checks++;
    if (init_rise_cyc != last_init_cyc + 1) begin
      failures++;
      $display("FAIL init_done_timing got=%0d exp=%0d", init_rise_cyc, last_init_cyc + 1);
    end
    checks++;
    if (bus.EN_WB !== 1'b0 || bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL post_init_idle got en=%b busy=%b exp 0 0", bus.EN_WB, bus.BUSY);
    end
  endtask

  task automatic test_init_stall();
    logic          held;
    logic [AW-1:0] held_a;
    idle_inputs();
    rst = 1'b1;
    step();
    clear_log();
    rst = 1'b0;
    bus.ACC_CTRL = 1'b1; // rows during the sweep must be ignored
    bus.WRITE_IN = 1'b1;
    bus.ODST_IN = 4'h3;
    bus.DIN = 64'h77;
    for (int i = 0; i < 80; i++) begin
      bus.MEM_RDY = (i % 2 == 0);
      held = (bus.EN_WB === 1'b1) && !bus.MEM_RDY;
      held_a = bus.ODST_WB;
      step();
      bus.ACC_CTRL = 1'b0;
      if (held) begin
        checks++;
        if (bus.EN_WB !== 1'b1 || bus.ODST_WB !== held_a || bus.WDATA_WB !== '0) begin
          failures++;
          $display("FAIL init_hold got en=%b a=%h d=%h exp en=1 a=%h d=0", bus.EN_WB,
                   bus.ODST_WB, bus.WDATA_WB, held_a);
        end
      end
      if (bus.INIT_DONE === 1'b1) break;
    end
    bus.WRITE_IN = 1'b0;
    bus.MEM_RDY = 1'b1;
    checks++;
    if (bus.INIT_DONE !== 1'b1 || wq_addr.size() != 16) begin
      failures++;
      $display("FAIL stall_init_count got done=%b n=%0d exp 1 16", bus.INIT_DONE, wq_addr.size());
    end
    for (int i = 0; i < 16 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== AW'(i)) begin
        failures++; $display("FAIL stall_init_order[%0d] got=%h exp=%h", i, wq_addr[i], i);
      end
    end
    checks++;
    if (bus.ERR_OVF !== 1'b0 || n_load != 0) begin
      failures++;
      $display("FAIL init_ignore_rows got ovf=%b loads=%0d exp 0 0", bus.ERR_OVF, n_load);
    end
    clr_pulse();
  endtask

  task automatic test_tile();
    clear_log();
    bus.ROW_TOTAL = 3'd3;
    acc_pulse();
    row(4'd5, 64'hA); row(4'd9, 64'hB); row(4'd2, 64'hC);
    repeat (4) step();
    checks++;
    if (n_load != 1 || bus.BUSY !== 1'b1 || bus.EN_WB !== 1'b0) begin
      failures++;
      $display("FAIL tile_wait_gnt got loads=%0d busy=%b en=%b exp 1 1 0", n_load, bus.BUSY,
               bus.EN_WB);
    end
    bus.STORE_GNT = 1'b1;
    step();
    bus.STORE_GNT = 1'b0;
    bus.MEM_RDY = 1'b0;
    step();
    checks++;
    if (bus.EN_WB !== 1'b1 || bus.ODST_WB !== 4'd5 || bus.WDATA_WB !== 64'hA) begin
      failures++;
      $display("FAIL store_hold got en=%b a=%h d=%h exp 1 5 a", bus.EN_WB, bus.ODST_WB,
               bus.WDATA_WB);
    end
    bus.MEM_RDY = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (n_store != 0) break;
      step();
    end
    step(); step();
    checks++;
    if (n_store != 1 || n_load != 1 || bus.BUSY !== 1'b0 || bus.EN_WB !== 1'b0) begin
      failures++;
      $display("FAIL tile_done got stores=%0d loads=%0d busy=%b en=%b exp 1 1 0 0", n_store,
               n_load, bus.BUSY, bus.EN_WB);
    end
    checks++;
    if (wq_addr.size() != 3 || wq_addr[0] !== 4'd5 || wq_data[0] !== 64'hA ||
        wq_addr[1] !== 4'd9 || wq_data[1] !== 64'hB || wq_addr[2] !== 4'd2 ||
        wq_data[2] !== 64'hC) begin
      failures++;
      $display("FAIL tile_writes got n=%0d first=%h:%h exp 3 writes 5:a 9:b 2:c",
               wq_addr.size(), wq_addr[0], wq_data[0]);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    bus.ROW_TOTAL = 3'd2;
    acc_pulse();
    row(4'd1, 64'h1); row(4'd2, 64'h2); row(4'd3, 64'h3);
    step();
    checks++;
    if (bus.ERR_OVF !== 1'b1 || n_load != 1 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set got ovf=%b loads=%0d busy=%b exp 1 1 1", bus.ERR_OVF, n_load,
               bus.BUSY);
    end
    clr_pulse();
    checks++;
    if (bus.ERR_OVF !== 1'b0 || bus.BUSY !== 1'b0 || bus.EN_WB !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear got ovf=%b busy=%b en=%b exp 0 0 0", bus.ERR_OVF, bus.BUSY,
               bus.EN_WB);
    end
    repeat (3) step();
    checks++;
    if (n_store != 0 || wq_addr.size() != 0) begin
      failures++;
      $display("FAIL overflow_no_store got stores=%0d writes=%0d exp 0 0", n_store,
               wq_addr.size());
    end
  endtask

  task automatic test_clear_mid_store();
    clear_log();
    bus.ROW_TOTAL = 3'd2;
    acc_pulse();
    row(4'd1, 64'h11); row(4'd2, 64'h22);
    step(); step();
    bus.STORE_GNT = 1'b1;
    step();
    bus.STORE_GNT = 1'b0;
    step();
    checks++;
    if (bus.EN_WB !== 1'b1 || bus.ODST_WB !== 4'd2) begin
      failures++;
      $display("FAIL mid_store_second got en=%b a=%h exp 1 2", bus.EN_WB, bus.ODST_WB);
    end
    bus.MEM_RDY = 1'b0;
    bus.CLR_DP = 1'b1;
    step();
    bus.CLR_DP = 1'b0;
    bus.MEM_RDY = 1'b1;
    checks++;
    if (bus.EN_WB !== 1'b0 || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL mid_store_clear got en=%b busy=%b exp 0 0", bus.EN_WB, bus.BUSY);
    end
    repeat (3) step();
    checks++;
    if (n_store != 0 || wq_addr.size() != 1 || wq_addr[0] !== 4'd1 || wq_data[0] !== 64'h11) begin
      failures++;
      $display("FAIL mid_store_partial got stores=%0d writes=%0d exp 0 1 (1:11)", n_store,
               wq_addr.size());
    end
    acc_pulse();
    row(4'd6, 64'h66); row(4'd8, 64'h88);
    step(); step();
    bus.STORE_GNT = 1'b1;
    step();
    bus.STORE_GNT = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (n_store != 0) break;
      step();
    end
    step();
    checks++;
    if (n_store != 1 || wq_addr.size() != 3 || wq_addr[1] !== 4'd6 || wq_data[1] !== 64'h66 ||
        wq_addr[2] !== 4'd8 || wq_data[2] !== 64'h88) begin
      failures++;
      $display("FAIL after_clear_tile got stores=%0d writes=%0d exp 1 3 (6:66 8:88)", n_store,
               wq_addr.size());
    end
  endtask

  task automatic test_same_addr();
    logic [AW-1:0] ea0, ea1;
    logic [DW-1:0] ed0, ed1;
    logic          e_load, e_ovf;
`ifdef WBUF_MERGE_EN
    ea0 = 4'd3; ed0 = 64'd15; ea1 = 4'd7; ed1 = 64'd1; e_load = 1'b0; e_ovf = 1'b0;
`else
    ea0 = 4'd3; ed0 = 64'd10; ea1 = 4'd3; ed1 = 64'd5; e_load = 1'b1; e_ovf = 1'b1;
`endif
    clear_log();
    bus.ROW_TOTAL = 3'd2;
    acc_pulse();
    row(4'd3, 64'd10); row(4'd3, 64'd5); row(4'd7, 64'd1);
    checks++;
    if (bus.LOAD_DONE !== e_load || bus.ERR_OVF !== e_ovf) begin
      failures++;
      $display("FAIL same_addr_flags got ld=%b ovf=%b exp %b %b", bus.LOAD_DONE, bus.ERR_OVF,
               e_load, e_ovf);
    end
    step(); step();
    bus.STORE_GNT = 1'b1;
    step();
    bus.STORE_GNT = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (n_store != 0) break;
      step();
    end
    step();
    checks++;
    if (n_store != 1 || n_load != 1 || wq_addr.size() != 2 || wq_addr[0] !== ea0 ||
        wq_data[0] !== ed0 || wq_addr[1] !== ea1 || wq_data[1] !== ed1) begin
      failures++;
      $display("FAIL same_addr_writes got n=%0d %h:%0d %h:%0d exp 2 %h:%0d %h:%0d",
               wq_addr.size(), wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], ea0, ed0, ea1,
               ed1);
    end
    clr_pulse();
    checks++;
    if (bus.ERR_OVF !== 1'b0 || bus.INIT_DONE !== 1'b1) begin
      failures++;
      $display("FAIL clear_keeps_init got ovf=%b init=%b exp 0 1", bus.ERR_OVF, bus.INIT_DONE);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_init_stall();
    test_tile();
    test_overflow();
    test_clear_mid_store();
    test_same_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
